// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide, one bit per cycle, registered result
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nx;

    logic [2:0]         op_q;
    logic               neg;
    logic [WIDTH-1:0]   m;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic               a_sgn, b_sgn, sa, sb, div_zero, ovf, fast, accept;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_sh, div_df;
    logic [2*WIDTH-1:0] mul_nx, div_nx, prod;
    logic [WIDTH-1:0]   quo, rem, fix_val;

    assign a_sgn    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    assign b_sgn    = op[2] ? ~op[0] : ~op[1];
    assign sa       = a_sgn & a[WIDTH-1];
    assign sb       = b_sgn & b[WIDTH-1];
    assign abs_a    = sa ? -a : a;
    assign abs_b    = sb ? -b : b;
    assign div_zero = op[2] && (b == '0);
    assign ovf      = op[2] && !op[0] && (a == MIN) && (&b);
    assign fast     = div_zero | ovf;
    assign accept   = start && !flush && (state == IDLE || state == DONE);

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step
    assign div_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_df = div_sh - {1'b0, m};
    assign div_nx = div_df[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {div_df[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod    = neg ? -acc : acc;
    assign quo     = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem     = neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign fix_val = op_q[2] ? (op_q[1] ? rem : quo)
                             : (op_q[1:0] == 2'b00 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    always_comb begin
        state_nx = flush ? IDLE
                 : accept ? (fast ? FIX : CALC)
                 : state == CALC ? (cnt == LAST ? FIX : CALC)
                 : state == FIX ? DONE
                 : IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Fast-path results are preloaded into acc with neg cleared so FIX selects them unchanged
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q   <= '0;
            neg    <= 1'b0;
            m      <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                op_q <= op;
                cnt  <= '0;
                neg  <= fast ? 1'b0 : ((op[2] && op[1]) ? sa : sa ^ sb);
                m    <= op[2] ? abs_b : abs_a;
                acc  <= div_zero ? {a, {WIDTH{1'b1}}}
                      : ovf ? {{WIDTH{1'b0}}, MIN}
                      : {{WIDTH{1'b0}}, op[2] ? abs_a : abs_b};
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                acc <= op_q[2] ? div_nx : mul_nx;
            end
            if (state == FIX && !flush) result <= fix_val;
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed self-checking bench for mdu_iter (WIDTH=32)
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Pulses start for one edge, then waits (bounded) for done; lat counts edges from start edge to done
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat, output int bcnt);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (!done && lat < 100) begin
            bcnt += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        res = result;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
        #8 rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat, bc;
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, lat, bc);
        checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_7x-3: got %h expected ffffffeb", r); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL mul_latency: got %0d expected 34", lat); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 33", bc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_at_done: got %b expected 0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done); end
    endtask

    task automatic test_mulh();
        logic [31:0] r; int lat, bc;
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, r, lat, bc);
        checks++; if (r !== 32'h4000_0000) begin errors++; $display("FAIL mulh_min: got %h expected 40000000", r); end
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc);
        checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_ones: got %h expected fffffffe", r); end
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2, r, lat, bc);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu_-1x2: got %h expected ffffffff", r); end
    endtask

    task automatic test_div();
        logic [31:0] r; int lat, bc;
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, r, lat, bc);
        checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_-7/2: got %h expected fffffffd", r); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency: got %0d expected 34", lat); end
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, r, lat, bc);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_-7/2: got %h expected ffffffff", r); end
        run_op(3'b101, 32'd100, 32'd7, r, lat, bc);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_100/7: got %h expected 0000000e", r); end
        run_op(3'b111, 32'd100, 32'd7, r, lat, bc);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_100/7: got %h expected 00000002", r); end
    endtask

    task automatic test_special();
        logic [31:0] r; int lat, bc;
        run_op(3'b101, 32'd5, 32'd0, r, lat, bc);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by_zero: got %h expected ffffffff", r); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL fast_latency: got %0d expected 2", lat); end
        checks++; if (bc !== 1) begin errors++; $display("FAIL fast_busy_cycles: got %0d expected 1", bc); end
        run_op(3'b111, 32'd5, 32'd0, r, lat, bc);
        checks++; if (r !== 32'd5) begin errors++; $display("FAIL remu_by_zero: got %h expected 00000005", r); end
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc);
        checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow: got %h expected 80000000", r); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL ovf_latency: got %0d expected 2", lat); end
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL rem_overflow: got %h expected 00000000", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat, bc;
        run_op(3'b000, 32'd6, 32'd9, r, lat, bc);
        run_op(3'b101, 32'd81, 32'd9, r, lat, bc);
        checks++; if (r !== 32'd9) begin errors++; $display("FAIL b2b_result: got %h expected 00000009", r); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 33", bc); end
    endtask

    task automatic test_flush();
        logic [31:0] r; int lat, bc; logic saw;
        run_op(3'b000, 32'd3, 32'd4, r, lat, bc);
        checks++; if (r !== 32'd12) begin errors++; $display("FAIL flush_pre_mul: got %h expected 0000000c", r); end
        start = 1'b1; op = 3'b101; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
        saw = 1'b0;
        repeat (40) begin
            saw |= done;
            @(posedge clk); #1;
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL flush_no_done: got %b expected 0", saw); end
        checks++; if (result !== 32'd12) begin errors++; $display("FAIL flush_result_kept: got %h expected 0000000c", result); end
        start = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd5; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_beats_start: got %b expected 0", busy); end
        run_op(3'b101, 32'd100, 32'd7, r, lat, bc);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL post_flush_divu: got %h expected 0000000e", r); end
    endtask

    task automatic test_ignored_start();
        int lat;
        start = 1'b1; op = 3'b000; a = 32'd7; b = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (5) begin @(posedge clk); #1; lat++; end
        start = 1'b1; op = 3'b101; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; lat++;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL ignored_start_result: got %h expected ffffffeb", result); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL ignored_start_latency: got %0d expected 34", lat); end
    endtask

    task automatic test_reset_mid();
        logic saw;
        start = 1'b1; op = 3'b011; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h expected 00000000", result); end
        #4 rstn = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            saw |= done | busy;
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL midreset_no_done: got %b expected 0", saw); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_back_to_back();
        test_flush();
        test_ignored_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative RV32M multiply/divide unit for the single-cycle CPU datapath. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU one bit per cycle. It holds the 32-bit result registered for the writeback 4:1 select, where it occupies one data input. While an operation is in flight, `busy` stalls PC/pipeline advance.

## Interface
- Clocking: one clock; reset is asynchronous and active-low.
- `WIDTH`, default 32: operand/result width; iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch operation; sampled only in IDLE or DONE.
- `op`  in  3  funct3 code:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`  in  WIDTH  rs1 operand; sampled with `start`.
- `b`  in  WIDTH  rs2 operand; sampled with `start`.
- `flush`  in  1  synchronous abort of the in-flight operation.
- `busy`  out  1  high while the operation is in CALC or FIX.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle on.
- `result`  out  WIDTH  registered result; held until the next completion.

## Operation
- States:
  - IDLE: reset state.
  - CALC: `WIDTH` iterations.
  - FIX: sign correction and result write.
  - DONE: one cycle.
- IDLE/DONE + `start` → CALC. Latch op, |a|, |b|, sign flags; count=0.
- Otherwise DONE → IDLE.
- Multiply:
  - Unsigned shift-add into a 2·WIDTH accumulator, 1 bit per cycle.
  - Sign handling: MUL/MULH treat both operands as signed; MULHSU treats a signed, b unsigned; MULHU treats both unsigned.
  - Product is negated (2·WIDTH two's complement) when operand signs differ.
  - MUL returns the low half; the others return the high half.
- Divide:
  - Restoring division on magnitudes, 1 quotient bit per cycle.
  - Quotient sign = sa^sb (DIV only). Remainder sign = sa (REM only).
- CALC with count = WIDTH-1 → FIX. FIX → DONE; `result` is written on that edge.
- Special cases take the fast path, skipping CALC: the `start` edge goes directly to FIX with the result precomputed.
  - Divide by zero: DIV/DIVU → all-ones; REM/REMU → a.
  - Signed overflow (DIV/REM with a=0x8000_0000, b=0xFFFF_FFFF): DIV → 0x8000_0000; REM → 0.
- `start` while CALC/FIX: ignored, no queueing.
- `flush` in CALC/FIX → IDLE on the next edge. No `done`; `result` keeps its previous value.
- `flush` with `start` in the same cycle: flush wins, start is dropped.
- `flush` in IDLE/DONE: IDLE, no other effect.

## Timing
- Reset (async, rstn=0): state=IDLE, `busy`=0, `done`=0, `result`=0, count=0, accumulators=0.
- Reset mid-operation aborts immediately; no `done` follows.
- Normal latency, with `start` sampled at edge E0:
  - CALC edges are E1..E32; E32 moves to FIX.
  - E33 writes `result` and enters DONE.
  - `done`=1 during the cycle after E33, i.e. 34 cycles from `start` to `done` for WIDTH=32.
- `busy`=1 from E0 through E33; it falls in the same cycle `done` rises.
- Fast-path latency: E0 → FIX, E1 → DONE. `done` is high after E1; `busy` is high only between E0 and E1.
- `done` is high for exactly one cycle. Back-to-back: `start` during DONE is accepted, and `busy` is high again the next cycle.
- `result` is stable from the `done` cycle until the next FIX edge. Writeback may select it during `done` or any later cycle.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Multiply 7 × -3:
  - MUL with a=7, b=0xFFFF_FFFD → result 0xFFFF_FFEB.
  - `done` exactly 34 cycles after the `start` edge.
  - `busy` high for 33 cycles.
- High-half multiplies:
  - MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000.
  - MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE.
  - MULHSU a=0xFFFF_FFFF, b=2 → 0xFFFF_FFFF.
- Signed division -7 / 2:
  - DIV with a=0xFFFF_FFF9, b=2 → 0xFFFF_FFFD.
  - REM on the same operands → 0xFFFF_FFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases:
  - DIVU 5/0 → 0xFFFF_FFFF, with `done` 2 cycles after `start`.
  - REMU 5/0 → 5.
  - DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; REM on the same operands → 0.
- Flush:
  - Complete MUL 3×4=12, then start DIVU 100/7 and assert `flush` at CALC iteration 10.
  - `busy`=0 next cycle, no `done`, `result` still 12.
  - A fresh `start` is then accepted normally.
- Reset and ignored start:
  - `rstn` low mid-CALC → `busy`, `done`, `result` go to 0 asynchronously.
  - `start` pulsed during CALC with different operands → ignored; the original result is delivered.
